// File: rtl/mem_pkg.sv
// Shared memory-side types and constants for the core's posted-write path.
// Used by store_buffer (forwarding macro: STORE_BUFFER_FORWARD_EN) and store_fifo.
package mem_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int WORD_LSB         = 2;

    // Native 32-bit core store as it leaves the buffer.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order entry storage for the store buffer: pointers, occupancy and full/empty.
// Push is ignored when full and pop is ignored when empty.
module store_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [AW-1:0]             push_addr,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count,
    output logic [PW-1:0]             rd_ptr,
    output logic [DEPTH-1:0][AW-1:0]  entry_addr,
    output logic [DEPTH-1:0][DW-1:0]  entry_data
);

    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entries are cleared on reset so the head/forward outputs read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            entry_addr <= '0;
            entry_data <= '0;
        end else begin
            if (do_push) begin
                entry_addr[wr_ptr] <= push_addr;
                entry_data[wr_ptr] <= push_data;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core and data memory, drained in store order.
// Define STORE_BUFFER_FORWARD_EN to build load forwarding; otherwise ld_hit/ld_data read 0.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic                     full;
    logic                     empty;
    logic [PW-1:0]            rd_ptr;
    logic [DEPTH-1:0][AW-1:0] entry_addr;
    logic [DEPTH-1:0][DW-1:0] entry_data;
    logic                     unused_ld;

    // Memory handshake: the head transfers on a cycle with mem_valid && mem_ready;
    // mem_valid stays high and mem_addr/mem_wdata hold until that happens.
    assign mem_valid = !empty;
    assign mem_addr  = entry_addr[rd_ptr];
    assign mem_wdata = entry_data[rd_ptr];

    // No full-bypass: a dequeue in the same cycle does not free a slot for the core.
    assign cpu_stall = cpu_we && full;

    store_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (cpu_we),
        .push_addr  (cpu_addr),
        .push_data  (cpu_wdata),
        .pop        (mem_valid && mem_ready),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .entry_addr (entry_addr),
        .entry_data (entry_data)
    );

`ifdef STORE_BUFFER_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match, nearest wr_ptr, wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) &&
                (entry_addr[fwd_idx][AW-1:WORD_LSB] == ld_addr[AW-1:WORD_LSB])) begin
                ld_hit  = 1'b1;
                ld_data = entry_data[fwd_idx];
            end
        end
    end

    assign unused_ld = ^ld_addr[WORD_LSB-1:0];
`else
    assign ld_hit    = 1'b0;
    assign ld_data   = '0;
    assign unused_ld = ^ld_addr;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue model of pending stores checked every cycle,
// plus hand-computed expectations for the reset, stall, forwarding and wrap cases.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [CW-1:0] count;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    // Pending stores, oldest first: {addr, data}.
    logic [AW+DW-1:0] exp_q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Model update on the active edge, from bench inputs and model state only.
    always @(posedge clk) begin
        if (reset) begin
            int sz;
            sz = exp_q.size();
            if (sz != 0 && mem_ready) void'(exp_q.pop_front());
            if (cpu_we && sz < DEPTH) exp_q.push_back({cpu_addr, cpu_wdata});
        end
    end

    // Buffered stores vanish on reset.
    always @(negedge reset) exp_q.delete();

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            logic          e_hit;
            logic [DW-1:0] e_data;
            check("count", count, exp_q.size());
            check("mem_valid", mem_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("mem_addr", mem_addr, exp_q[0][AW+DW-1:DW]);
                check("mem_wdata", mem_wdata, exp_q[0][DW-1:0]);
            end
            check("cpu_stall", cpu_stall, cpu_we && exp_q.size() == DEPTH);
            e_hit  = 1'b0;
            e_data = '0;
            if (FWD) begin
                foreach (exp_q[i]) begin
                    if (exp_q[i][AW+DW-1:DW+2] == ld_addr[AW-1:2]) begin
                        e_hit  = 1'b1;
                        e_data = exp_q[i][DW-1:0];
                    end
                end
            end
            check("ld_hit", ld_hit, e_hit);
            check("ld_data", ld_data, e_data);
            if (mem_valid && mem_ready) n_xfer++;
        end
    end

    // Driver tasks
    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic rdy);
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        mem_ready = rdy;
    endtask

    task automatic step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rdy);
        drive(we, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  i;
        int  cyc;
        logic stalled;

        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        ld_addr = '0;
        #2;
        check("rst_count", count, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_ld_hit", ld_hit, 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single store, latency one edge, drained on the next
        ld_addr = 32'd100;
        step(1'b1, 32'd100, 32'd7, 1'b1);
        check("t1_valid", mem_valid, 1);
        check("t1_addr", mem_addr, 100);
        check("t1_wdata", mem_wdata, 7);
        check("t1_count1", count, 1);
        step(1'b0, '0, '0, 1'b1);
        check("t1_count0", count, 0);
        check("t1_idle", mem_valid, 0);

        // Fill, stall, no full-bypass, ordered drain
        ld_addr = '0;
        for (int k = 0; k < 4; k++) step(1'b1, 32'h60 + 32'(4 * k), 32'(k + 1), 1'b0);
        check("t2_full_count", count, 4);
        check("t2_head", mem_addr, 32'h60);
        drive(1'b1, 32'h70, 32'd5, 1'b0);
        #1;
        check("t2_stall", cpu_stall, 1);
        @(posedge clk);
        #1;
        check("t2_hold_count", count, 4);
        check("t2_hold_addr", mem_addr, 32'h60);
        check("t2_hold_wdata", mem_wdata, 1);
        drive(1'b1, 32'h70, 32'd5, 1'b1);
        #1;
        check("t2_no_bypass", cpu_stall, 1);
        @(posedge clk);
        #1;
        check("t2_after_deq_count", count, 3);
        check("t2_second", mem_addr, 32'h64);
        step(1'b0, '0, '0, 1'b1);
        check("t2_third", mem_addr, 32'h68);
        step(1'b0, '0, '0, 1'b1);
        check("t2_fourth", mem_addr, 32'h6C);
        check("t2_fourth_data", mem_wdata, 4);
        step(1'b0, '0, '0, 1'b1);
        check("t2_empty", count, 0);

        // Forwarding: youngest match, word granularity
        step(1'b1, 32'h64, 32'd7, 1'b0);
        step(1'b1, 32'h64, 32'd9, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        ld_addr = 32'h64;
        #1;
        check("t3_hit_64", ld_hit, FWD ? 1 : 0);
        check("t3_data_64", ld_data, FWD ? 9 : 0);
        ld_addr = 32'h66;
        #1;
        check("t3_hit_66", ld_hit, FWD ? 1 : 0);
        check("t3_data_66", ld_data, FWD ? 9 : 0);
        ld_addr = 32'h60;
        #1;
        check("t3_miss_60", ld_hit, 0);
        ld_addr = 32'h64;

        // Simultaneous enqueue and dequeue at count 2
        step(1'b1, 32'h80, 32'hAA, 1'b1);
        check("t4_count", count, 2);
        check("t4_head_addr", mem_addr, 32'h64);
        check("t4_head_data", mem_wdata, 9);
        step(1'b0, '0, '0, 1'b1);
        check("t4_next", mem_addr, 32'h80);
        step(1'b0, '0, '0, 1'b1);
        check("t4_empty", count, 0);

        // Asynchronous reset mid-operation discards everything
        for (int k = 0; k < 3; k++) step(1'b1, 32'h300 + 32'(4 * k), 32'(k + 1), 1'b0);
        check("t5_count3", count, 3);
        drive(1'b0, '0, '0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_count", count, 0);
        check("t5_rst_valid", mem_valid, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_hit", ld_hit, 0);
        #2;
        reset = 1'b1;
        step(1'b1, 32'd100, 32'd7, 1'b1);
        check("t5_post_addr", mem_addr, 100);
        check("t5_post_data", mem_wdata, 7);
        step(1'b0, '0, '0, 1'b1);
        check("t5_post_empty", count, 0);

        // Ten back-to-back stores, mem_ready toggling, core holds stalled stores
        ld_addr = 32'h204;
        i   = 0;
        cyc = 0;
        while (i < 10 && cyc < 100) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), cyc[0]);
            #1;
            stalled = cpu_stall;
            @(posedge clk);
            #1;
            if (!stalled) i++;
            cyc++;
        end
        check("t6_all_enqueued", i, 10);
        cyc = 0;
        while (count != 0 && cyc < 40) begin
            step(1'b0, '0, '0, cyc[0]);
            cyc++;
        end
        check("t6_drained", count, 0);
        check("xfer_total", n_xfer, 19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core and data memory. Captures every core store (`MemWrite`, `ALUResult` as address, `WriteData`) into a small in-order FIFO and drains it to data memory over a valid/ready handshake. This decouples core progress from memory write latency. Optionally forwards buffered store data to core loads so a load never observes stale memory.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2
- `AW`, 32: address width
- `DW`, 32: data width

- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `cpu_we` in 1: store request (core `MemWrite`)
- `cpu_addr` in AW: store address (core `ALUResult`)
- `cpu_wdata` in DW: store data (core `WriteData`)
- `cpu_stall` out 1: store refused this cycle; core must hold the store
- `ld_addr` in AW: core load address for forwarding lookup
- `ld_hit` out 1: a buffered store matches `ld_addr`
- `ld_data` out DW: data of the youngest matching entry
- `mem_valid` out 1: head entry presented to memory
- `mem_addr` out AW: head address
- `mem_wdata` out DW: head data
- `mem_ready` in 1: memory accepts the head this cycle
- `count` out $clog2(DEPTH+1): occupied entries

## Operation
- State: entry array, `wr_ptr`, `rd_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH), `count`.
- Enqueue when `cpu_we && count != DEPTH`. Entry written at `wr_ptr`, then `wr_ptr` increments.
- `cpu_stall = cpu_we && count == DEPTH`, combinational. A same-cycle dequeue does not lift the stall; there is no full-bypass.
- Dequeue when `mem_valid && mem_ready`. `rd_ptr` increments.
- `mem_valid = (count != 0)`. `mem_addr`/`mem_wdata` come combinationally from the entry at `rd_ptr`.
- Handshake: while `mem_valid && !mem_ready`, `mem_addr`/`mem_wdata` stay stable. `mem_valid` never drops without a transfer, except on reset.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Drain order equals store order (strict FIFO). There is no write merging.
- Forwarding compares `ld_addr[AW-1:2]` against occupied entries only.
  - The youngest match (closest to `wr_ptr`) wins.
  - Result is combinational; an entry being dequeued this cycle still counts.
  - A store being enqueued this cycle is not visible.

## Timing
- Reset (asynchronous, `reset`=0): pointers, `count`, `mem_valid`, `cpu_stall`, `ld_hit` = 0; `ld_data`, `mem_addr`, `mem_wdata` = 0 (entry array cleared).
- Reset mid-operation: all buffered stores are discarded immediately, with no drain. `mem_valid` falls asynchronously.
- Store latency: `cpu_we` sampled at edge N → `mem_valid`=1 after edge N, so memory can accept at edge N+1.
- Throughput: one enqueue and one dequeue per cycle.
- Empty: `mem_valid`=0; `mem_ready` is ignored.
- Full: `cpu_stall`=1 whenever `cpu_we`=1; entries are not overwritten.

## Configuration
- `STORE_BUFFER_FORWARD_EN` defined: forwarding comparators are built and `ld_hit`/`ld_data` operate as above.
- Not defined: comparators are omitted, `ld_hit` is tied 0 and `ld_data` is tied 0. Ports remain present, and FIFO behaviour is identical.

## Structure
- Shared package `mem_pkg`:
  - `store_entry_t` struct {addr[AW], data[DW]}
  - `SB_DEPTH_DEFAULT` = 4
  - word-offset constant `WORD_LSB` = 2
- One sub-module, `store_fifo`: pointers, count, entry storage, full/empty. `store_buffer` adds the stall logic, handshake mapping and the forwarding search.

## Test plan
- Store 7 to 100 at edge N with `mem_ready`=1 → `mem_valid`=1, `mem_addr`=100, `mem_wdata`=7 after N; transferred at N+1; `count` back to 0.
- `mem_ready`=0, stores to 0x60/0x64/0x68/0x6C → `count`=4; fifth store → `cpu_stall`=1, not enqueued. Raise `mem_ready` → the four drain in order, one per cycle, with stable outputs while stalled.
- With `STORE_BUFFER_FORWARD_EN`: store 0x64←7 then 0x64←9 (`mem_ready`=0). `ld_addr`=0x64 → `ld_hit`=1, `ld_data`=9. `ld_addr`=0x66 → hit, 9. `ld_addr`=0x60 → `ld_hit`=0. Without the macro → `ld_hit`=0.
- `count`=2 with enqueue and dequeue in the same cycle → `count` stays 2; the next head is the second-oldest store.
- `count`=3 with `reset` pulsed low between edges → `count`=0 and `mem_valid`=0 immediately, with no memory transfers. After release, a store to 100 with data 7 drains normally.
- 10 stores back-to-back with `mem_ready` toggling every cycle → all 10 arrive in order with correct data. Pointers wrap twice; no loss or duplication.
